// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-priority arbiter sharing one single-port memory between fetch and data requesters
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_e;

  // Abort fires on the TIMEOUT-th wait cycle, i.e. when the count of prior waits is TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        if_ready_q, mem_ready_q, bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_sel_q   <= 4'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            state_q     <= MEM_BUSY;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
            bus_sel_q   <= mem_sel;
          end else if (if_req) begin
            state_q     <= IF_BUSY;
            cnt_q       <= 8'd0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= 32'd0;
            bus_sel_q   <= 4'b1111;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          // An ack on the timeout cycle still wins: it is a normal completion.
          if (bus_ack || cnt_q == TO_LAST) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            bus_err_q <= ~bus_ack;
            if (state_q == IF_BUSY) begin
              if_rdata_q <= bus_ack ? bus_rdata : 32'd0;
              if_ready_q <= 1'b1;
            end else begin
              mem_rdata_q <= bus_ack ? bus_rdata : 32'd0;
              mem_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata          = if_rdata_q;
  assign if_ready          = if_ready_q;
  assign mem_rdata         = mem_rdata_q;
  assign mem_ready         = mem_ready_q;
  assign bus_req           = bus_req_q;
  assign bus_we            = bus_we_q;
  assign bus_addr          = bus_addr_q;
  assign bus_wdata         = bus_wdata_q;
  assign bus_sel           = bus_sel_q;
  assign bus_err           = bus_err_q;
  assign stallreq_from_if  = if_req & ~if_ready_q;
  assign stallreq_from_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic [31:0] m_if_rdata, m_mem_rdata, m_bus_addr, m_bus_wdata;
  logic        m_if_ready, m_mem_ready, m_bus_req, m_bus_we, m_stall_if, m_stall_mem, m_bus_err;
  logic [3:0]  m_bus_sel;
  logic [31:0] t_if_rdata, t_mem_rdata, t_bus_addr, t_bus_wdata;
  logic        t_if_ready, t_mem_ready, t_bus_req, t_bus_we, t_stall_if, t_stall_mem, t_bus_err;
  logic [3:0]  t_bus_sel;

  int   asserts = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(m_if_rdata), .if_ready(m_if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(m_mem_rdata), .mem_ready(m_mem_ready),
    .bus_req(m_bus_req), .bus_we(m_bus_we), .bus_addr(m_bus_addr), .bus_wdata(m_bus_wdata),
    .bus_sel(m_bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq_from_if(m_stall_if), .stallreq_from_mem(m_stall_mem), .bus_err(m_bus_err)
  );

  mem_arbiter #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(t_if_rdata), .if_ready(t_if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(t_mem_rdata), .mem_ready(t_mem_ready),
    .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_wdata(t_bus_wdata),
    .bus_sel(t_bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq_from_if(t_stall_if), .stallreq_from_mem(t_stall_mem), .bus_err(t_bus_err)
  );

  // Completion monitor for the default-TIMEOUT instance.
  always @(negedge clk) begin
    if (!rst && (m_if_ready || m_mem_ready)) begin
      asserts++;
      if (m_if_ready && m_mem_ready) begin
        fails++;
        $display("FAIL ready_exclusive: if_ready=%b mem_ready=%b, required not both", m_if_ready, m_mem_ready);
      end else if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ready: if_ready=%b mem_ready=%b with no transfer expected", m_if_ready, m_mem_ready);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_if !== m_if_ready || (e.is_if ? m_if_rdata : m_mem_rdata) !== e.rdata || m_bus_err !== 1'b0) begin
          fails++;
          $display("FAIL sb_completion: side_if=%b rdata=%h err=%b, required side_if=%b rdata=%h err=0",
                   m_if_ready, e.is_if ? m_if_rdata : m_mem_rdata, m_bus_err, e.is_if, e.rdata);
        end
      end
    end
  end

  task automatic wait_req(input bit use4, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((use4 ? t_bus_req : m_bus_req) === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_ack(input logic [31:0] d);
    bus_ack = 1'b1;
    bus_rdata = d;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    asserts++;
    if ({m_bus_req, m_bus_we, m_bus_addr, m_bus_wdata, m_bus_sel, m_if_rdata, m_mem_rdata,
         m_if_ready, m_mem_ready, m_bus_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: bus_req=%b addr=%h sel=%h if_rdata=%h, required all zero",
               m_bus_req, m_bus_addr, m_bus_sel, m_if_rdata);
    end
    rst = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    asserts++;
    if (m_bus_req !== 1'b0 || m_if_rdata !== 32'd0 || m_mem_rdata !== 32'd0) begin
      fails++;
      $display("FAIL idle_ack_ignored: bus_req=%b if_rdata=%h mem_rdata=%h, required 0/0/0",
               m_bus_req, m_if_rdata, m_mem_rdata);
    end
  endtask

  task automatic test_fetch();
    bit ok;
    sb.push_back('{1'b1, 32'h2401_0005});
    if_req = 1'b1;
    if_addr = 32'h0000_0100;
    #1;
    asserts++;
    if (m_stall_if !== 1'b1) begin
      fails++;
      $display("FAIL fetch_stall_high: got %b required 1", m_stall_if);
    end
    wait_req(1'b0, ok);
    asserts++;
    if (!ok || m_bus_addr !== 32'h100 || m_bus_we !== 1'b0 || m_bus_sel !== 4'hf || m_bus_wdata !== 32'd0) begin
      fails++;
      $display("FAIL fetch_bus: req_seen=%b addr=%h we=%b sel=%h wdata=%h, required 1/00000100/0/f/0",
               ok, m_bus_addr, m_bus_we, m_bus_sel, m_bus_wdata);
    end
    pulse_ack(32'h2401_0005);
    asserts++;
    if (m_if_ready !== 1'b1 || m_stall_if !== 1'b0 || m_bus_req !== 1'b0) begin
      fails++;
      $display("FAIL fetch_ready: if_ready=%b stall=%b bus_req=%b, required 1/0/0", m_if_ready, m_stall_if, m_bus_req);
    end
    if_req = 1'b0;
    @(negedge clk);
    asserts++;
    if (m_if_ready !== 1'b0) begin
      fails++;
      $display("FAIL fetch_ready_one_cycle: got %b required 0", m_if_ready);
    end
  endtask

  task automatic test_priority();
    bit ok;
    sb.push_back('{1'b0, 32'hA5A5_0001});
    sb.push_back('{1'b1, 32'h0BAD_F00D});
    if_req = 1'b1;
    if_addr = 32'h0000_0200;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h0000_2000;
    mem_sel = 4'hf;
    wait_req(1'b0, ok);
    asserts++;
    if (!ok || m_bus_addr !== 32'h2000 || m_bus_we !== 1'b0) begin
      fails++;
      $display("FAIL prio_mem_first: req_seen=%b addr=%h we=%b, required 1/00002000/0", ok, m_bus_addr, m_bus_we);
    end
    pulse_ack(32'hA5A5_0001);
    asserts++;
    if (m_mem_ready !== 1'b1 || m_if_ready !== 1'b0) begin
      fails++;
      $display("FAIL prio_mem_ready: mem_ready=%b if_ready=%b, required 1/0", m_mem_ready, m_if_ready);
    end
    mem_req = 1'b0;
    @(negedge clk);
    asserts++;
    if (m_bus_req !== 1'b0) begin
      fails++;
      $display("FAIL prio_done_gap: bus_req=%b required 0", m_bus_req);
    end
    wait_req(1'b0, ok);
    asserts++;
    if (!ok || m_bus_addr !== 32'h200) begin
      fails++;
      $display("FAIL prio_if_second: req_seen=%b addr=%h, required 1/00000200", ok, m_bus_addr);
    end
    pulse_ack(32'h0BAD_F00D);
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_delay();
    bit ok;
    sb.push_back('{1'b0, 32'h5A5A_0000});
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h10;
    mem_wdata = 32'hDEAD_BEEF;
    mem_sel = 4'b0011;
    wait_req(1'b0, ok);
    for (int i = 0; i < 5; i++) begin
      asserts++;
      if (!ok || m_bus_req !== 1'b1 || m_bus_we !== 1'b1 || m_bus_addr !== 32'h10 ||
          m_bus_wdata !== 32'hDEAD_BEEF || m_bus_sel !== 4'b0011) begin
        fails++;
        $display("FAIL store_stable[%0d]: req=%b we=%b addr=%h wdata=%h sel=%b, required 1/1/00000010/deadbeef/0011",
                 i, m_bus_req, m_bus_we, m_bus_addr, m_bus_wdata, m_bus_sel);
      end
      mem_addr = 32'hFFFF_0000 + 32'(i);
      mem_wdata = 32'h0;
      mem_sel = 4'b1100;
      mem_we = 1'b0;
      @(negedge clk);
    end
    pulse_ack(32'h5A5A_0000);
    asserts++;
    if (m_mem_ready !== 1'b1) begin
      fails++;
      $display("FAIL store_ready: mem_ready=%b required 1", m_mem_ready);
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1'b1, 32'hCAFE_F00D});
    if_req = 1'b1;
    if_addr = 32'h0000_0300;
    wait_req(1'b1, ok);
    pulse_ack(32'hCAFE_F00D);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0000_0304;
    wait_req(1'b1, ok);
    n = 0;
    while (ok && t_bus_req === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    asserts++;
    if (n != 4 || t_if_ready !== 1'b1 || t_bus_err !== 1'b1 || t_if_rdata !== 32'd0) begin
      fails++;
      $display("FAIL timeout_abort: wait_cycles=%0d ready=%b err=%b rdata=%h, required 4/1/1/00000000",
               n, t_if_ready, t_bus_err, t_if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    asserts++;
    if (t_bus_err !== 1'b0 || t_if_ready !== 1'b0 || m_bus_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: err=%b ready=%b main_err=%b, required 0/0/0", t_bus_err, t_if_ready, m_bus_err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1'b1, 32'h7777_1111});
    if_req = 1'b1;
    if_addr = 32'h0000_0308;
    wait_req(1'b1, ok);
    repeat (3) @(negedge clk);
    pulse_ack(32'h7777_1111);
    asserts++;
    if (!ok || t_if_ready !== 1'b1 || t_bus_err !== 1'b0 || t_if_rdata !== 32'h7777_1111) begin
      fails++;
      $display("FAIL timeout_ack_wins: ready=%b err=%b rdata=%h, required 1/0/77771111", t_if_ready, t_bus_err, t_if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h40;
    mem_sel = 4'hf;
    wait_req(1'b0, ok);
    #2 rst = 1'b1;
    #1;
    asserts++;
    if (!ok || m_bus_req !== 1'b0 || m_mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_abort: req_seen=%b bus_req=%b mem_ready=%b, required 1/0/0", ok, m_bus_req, m_mem_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{1'b0, 32'h4444_0040});
    wait_req(1'b0, ok);
    asserts++;
    if (!ok || m_bus_addr !== 32'h40) begin
      fails++;
      $display("FAIL reset_mid_rearb: req_seen=%b addr=%h, required 1/00000040", ok, m_bus_addr);
    end
    pulse_ack(32'h4444_0040);
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    sb.push_back('{1'b1, 32'h1111_0500});
    sb.push_back('{1'b1, 32'h2222_0504});
    if_req = 1'b1;
    if_addr = 32'h0000_0500;
    wait_req(1'b0, ok);
    pulse_ack(32'h1111_0500);
    if_addr = 32'h0000_0504;
    @(negedge clk);
    asserts++;
    if (!ok || m_bus_req !== 1'b0) begin
      fails++;
      $display("FAIL b2b_no_dup: bus_req=%b after DONE, required 0", m_bus_req);
    end
    @(negedge clk);
    asserts++;
    if (m_bus_req !== 1'b1 || m_bus_addr !== 32'h504) begin
      fails++;
      $display("FAIL b2b_second: bus_req=%b addr=%h, required 1/00000504", m_bus_req, m_bus_addr);
    end
    pulse_ack(32'h2222_0504);
    if_req = 1'b0;
    @(negedge clk);
    asserts++;
    if (m_bus_req !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: bus_req=%b required 0", m_bus_req);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store_delay();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drained: %0d completions outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles waited for bus_ack before abort.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high (`RstEnable).
REQ-004 SHALL have port if_req  input  1  fetch request, held high until if_ready.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_rdata  output  32  fetched word, registered.
REQ-007 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port mem_req  input  1  data request, held high until mem_ready.
REQ-009 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port mem_addr  input  32  data byte address.
REQ-011 SHALL have port mem_wdata  input  32  store data.
REQ-012 SHALL have port mem_sel  input  4  byte enables.
REQ-013 SHALL have port mem_rdata  output  32  load word, registered.
REQ-014 SHALL have port mem_ready  output  1  one-cycle data completion pulse.
REQ-015 SHALL have ports bus_req, bus_we (output 1), bus_addr, bus_wdata (output 32), bus_sel (output 4): shared single-port memory request, all registered.
REQ-016 SHALL have ports bus_ack  input  1 (transfer complete) and bus_rdata  input  32 (valid with bus_ack).
REQ-017 SHALL have ports stallreq_from_if, stallreq_from_mem  output  1  stall requests to the pipeline stall controller (`Stop = 1).
REQ-018 SHALL have port bus_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-020 In IDLE with mem_req=1, SHALL go to MEM_BUSY and latch mem_we/addr/wdata/sel onto bus outputs with bus_req=1, regardless of if_req (data strictly beats fetch).
REQ-021 In IDLE with mem_req=0 and if_req=1, SHALL go to IF_BUSY, drive bus_addr=if_addr, bus_we=0, bus_sel=4'b1111, bus_wdata=0, bus_req=1.
REQ-022 In a BUSY state, bus_req and all bus outputs SHALL stay constant until the bus_ack cycle; requester inputs changing mid-transfer SHALL be ignored.
REQ-023 On bus_ack in IF_BUSY: latch bus_rdata into if_rdata, bus_req=0 next cycle, go to DONE, if_ready=1 for exactly the DONE cycle.
REQ-024 On bus_ack in MEM_BUSY: same, using mem_rdata/mem_ready; mem_rdata SHALL also update on stores (value don't-care to consumers).
REQ-025 DONE SHALL last exactly one cycle, grant nothing, and return to IDLE; this prevents re-serving a requester whose req is still high while it sees ready.
REQ-026 Minimum latency: req seen in IDLE at cycle t, bus_req at t+1, bus_ack at earliest t+1, ready at t+2; IDLE at t+3.
REQ-027 stallreq_from_if SHALL equal if_req & ~if_ready; stallreq_from_mem SHALL equal mem_req & ~mem_ready (combinational from inputs and registered ready).
REQ-028 An 8-bit wait counter SHALL clear on entry to a BUSY state and increment each BUSY cycle without bus_ack.
REQ-029 When the counter reaches TIMEOUT without bus_ack: drop bus_req, load rdata of the active side with 32'h0, pulse bus_err and that side's ready in DONE.
REQ-030 bus_ack in IDLE or DONE SHALL be ignored; bus_ack in the same cycle as timeout SHALL count as a normal completion (no bus_err).
REQ-031 if_ready and mem_ready SHALL never be high in the same cycle; at most one bus transfer SHALL be outstanding.

Reset
REQ-032 rst=1 SHALL immediately (asynchronously) force state IDLE, counter 0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0, bus_err=0.
REQ-033 Reset during a BUSY state SHALL abandon the transfer with no ready pulse; after release, still-high requests SHALL be re-arbitrated from IDLE.

Verification
REQ-034 if_req=1, if_addr=32'h0000_0100, bus_ack one cycle after bus_req with bus_rdata=32'h2401_0005 -> if_ready one cycle with if_rdata=32'h2401_0005; stallreq_from_if high until that cycle.
REQ-035 if_req and mem_req (load, addr 32'h0000_2000) rise same cycle -> MEM served first, mem_ready pulse, DONE cycle, then IF transfer; if_ready strictly after mem_ready.
REQ-036 Store mem_addr=32'h10, mem_wdata=32'hDEAD_BEEF, mem_sel=4'b0011 with bus_ack delayed 5 cycles -> bus outputs stable all 5 cycles, mem_ready one cycle after ack.
REQ-037 TIMEOUT=4, bus_ack never asserted on fetch -> bus_req drops after 4 wait cycles, bus_err and if_ready pulse together, if_rdata=0.
REQ-038 rst asserted mid-MEM_BUSY -> bus_req low in the same cycle, no mem_ready; after release with mem_req still high, new transfer starts from IDLE.
REQ-039 Requester holds req high through its ready cycle and keeps it high for a new address -> no duplicate transfer in DONE; second transfer starts from IDLE.
